instr_register_param: RTL and testbench
=======================================

INSTR_REGISTER_PARAM -- requirements
Module: instr_register_param

Interface
REQ-001 Parameters SHALL be: OP_W, default 32, signed operand width; DEPTH, default 32, number of entries, power of two, at least 2; ADDR_W, default $clog2(DEPTH), pointer width.
REQ-002 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port load_en, input, 1: write request.
REQ-005 Port write_pointer, input, ADDR_W: write address.
REQ-006 Port operand_a, input, OP_W: signed operand A.
REQ-007 Port operand_b, input, OP_W: signed operand B.
REQ-008 Port opcode, input, opcode_t: ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV or MOD.
REQ-009 Port wr_ready, output, 1: write port can accept a request.
REQ-010 Port read_pointer, input, ADDR_W: read address.
REQ-011 Port instruction_word, output, instruction_t: registered read data {opc, op_a, op_b, result, err}.
REQ-012 Port rd_valid, output, 1: the entry read has been written since reset.

Function
REQ-013 A write SHALL be accepted on a rising edge where load_en=1 and wr_ready=1; load_en with wr_ready=0 SHALL be ignored, not queued.
REQ-014 Non-divide ops SHALL be written at the accepting edge.
- result is signed, 2*OP_W bits.
- ZERO gives 0; PASSA/PASSB give the sign-extended operand; ADD/SUB give the exact sign-extended sum or difference; MULT gives the full signed product with no truncation.
REQ-015 DIV/MOD with operand_b=0 SHALL write in a single cycle with result=0 and err=1.
REQ-016 Division SHALL truncate toward zero, and MOD SHALL take the sign of the dividend.
REQ-017 Read SHALL have 1-cycle latency: instruction_word and rd_valid reflect the read_pointer sampled at the previous edge.
REQ-018 Reading an entry in the same cycle it is written SHALL return the old contents (read-before-write).
REQ-019 Unwritten entries SHALL read as all-zero with opc=ZERO and rd_valid=0.
REQ-020 Pointers are ADDR_W bits and SHALL wrap naturally; no out-of-range access is possible.

Reset
REQ-021 While reset_n=0, the following SHALL be forced asynchronously:
- all entries to zero (opc=ZERO, err=0, valid bits 0);
- instruction_word to 0 and rd_valid to 0;
- the FSM to IDLE and wr_ready to 0.
REQ-022 wr_ready SHALL be 1 from the first edge after reset_n rises.
REQ-023 Reset during a divide SHALL abort it with no write to any entry.

Configuration
REQ-024 With macro INSTR_REG_DIVMOD_EN defined, DIV/MOD with operand_b≠0 SHALL use the iterative divider. Operation:
- FSM states IDLE→DIV_RUN→DIV_DONE→IDLE.
- The accepting edge N latches operands, address and opcode, and enters DIV_RUN with counter=OP_W.
- Edges N+1..N+OP_W perform one radix-2 restoring step on magnitudes each.
- DIV_DONE applies the signs, and edge N+OP_W+1 writes the entry (err=0) and returns to IDLE.
- wr_ready=1 only in IDLE.
REQ-025 Without INSTR_REG_DIVMOD_EN, all DIV/MOD SHALL write in a single cycle with result=0 and err=1. The divider and FSM are absent, and wr_ready SHALL be constantly 1 after reset.

Structure
REQ-026 The following SHALL live in shared package instr_register_pkg, sized from OP_W/ADDR_W parameters:
- opcode_t;
- the operand, result and address types;
- instruction_t.
REQ-027 The divider SHALL be one sub-module, instr_div_seq, with start/done handshake, OP_W parameter, and quotient and remainder outputs, present only under INSTR_REG_DIVMOD_EN.

Verification
REQ-028 Reset: hold reset_n low 2 cycles, then read all 32 locations → each word is 0, rd_valid=0, and wr_ready=1 after release.
REQ-029 ADD: a=-7, b=5 written at wp=3, then rp=3 → one cycle later result=-2, opc=ADD, rd_valid=1, err=0.
REQ-030 MULT: a=32'h7FFFFFFF, b=2 at wp=0 → result=64'h00000000FFFFFFFE; MULT a=-1, b=-1 → 1.
REQ-031 DIV with macro: DIV a=-17, b=5 at wp=31 →
- wr_ready low for 33 cycles;
- load_en pulses during that window are ignored;
- result=-3.
- MOD with the same operands → -2.
REQ-032 Error cases:
- DIV 20/0 → single-cycle write, result=0, err=1.
- Without the macro, DIV 20/4 → result=0, err=1, and wr_ready stays 1.
REQ-033 Reset abort and read-before-write:
- Assert reset_n 10 cycles into a DIV to wp=5 → after release entry 5 reads 0, rd_valid=0, wr_ready=1.
- Read wp=7 in the same cycle it is written → the old value is returned, and the new value appears on the next read.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register.
//
// Holds the opcode enumeration, operand/result/address types and the stored
// instruction word layout. Widths derive from OP_W_PKG / DEPTH_PKG; the
// register module checks at elaboration that its parameters agree with them.
package instr_register_pkg;

    localparam int unsigned OP_W_PKG   = 32;
    localparam int unsigned DEPTH_PKG  = 32;
    localparam int unsigned ADDR_W_PKG = $clog2(DEPTH_PKG);

    typedef enum logic [2:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [OP_W_PKG-1:0]   operand_t;
    typedef logic signed [2*OP_W_PKG-1:0] result_t;
    typedef logic        [ADDR_W_PKG-1:0] addr_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
        logic     err;
    } instruction_t;

    // Divide sequencer states (only used when the iterative divider is built)
    typedef enum logic [1:0] {
        IDLE,
        DIV_RUN,
        DIV_DONE
    } state_t;

    function automatic result_t sext_op(operand_t v);
        return {{OP_W_PKG{v[OP_W_PKG-1]}}, v};
    endfunction

endpackage

// File: rtl/instr_register_param_if.sv
// Bus interface of the instruction register.
//
// Signals:
//   load_en, write_pointer, operand_a, operand_b, opcode : write request
//   wr_ready                                             : write port can accept
//   read_pointer                                         : read address
//   instruction_word, rd_valid                           : registered read data
// Modports: master drives requests and read address, slave is the register.
interface instr_register_param_if;
    import instr_register_pkg::*;

    logic         load_en;
    addr_t        write_pointer;
    operand_t     operand_a;
    operand_t     operand_b;
    opcode_t      opcode;
    logic         wr_ready;
    addr_t        read_pointer;
    instruction_t instruction_word;
    logic         rd_valid;

    modport master (
        output load_en, write_pointer, operand_a, operand_b, opcode, read_pointer,
        input  wr_ready, instruction_word, rd_valid
    );

    modport slave (
        input  load_en, write_pointer, operand_a, operand_b, opcode, read_pointer,
        output wr_ready, instruction_word, rd_valid
    );

endinterface

// File: rtl/instr_div_seq.sv
// Iterative signed divider, one radix-2 restoring step per clock.
//
// Built only when INSTR_REG_DIVMOD_EN is defined.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : latch dividend/divisor and begin (divisor must be non-zero)
//   dividend, divisor   : signed OP_W-bit operands
//   done                : high during the final step; results valid from the next
//                         cycle until the next start
//   quotient            : signed OP_W+1 bits, truncated toward zero
//   remainder           : signed OP_W bits, sign of the dividend
`ifdef INSTR_REG_DIVMOD_EN
module instr_div_seq #(
    parameter int unsigned OP_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic signed [OP_W-1:0] dividend,
    input  logic signed [OP_W-1:0] divisor,
    output logic                   done,
    output logic signed [OP_W:0]   quotient,
    output logic signed [OP_W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(OP_W + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [OP_W-1:0]  quo_q, rem_q, dvs_q;
    logic             q_neg_q, r_neg_q;

    logic [OP_W-1:0]  dvd_mag, dvs_mag;
    logic [OP_W:0]    partial;
    logic [OP_W-1:0]  diff;
    logic             fits;
    logic [OP_W:0]    quo_ext;

    always_comb begin
        // Magnitude of the most negative value is still exact as unsigned
        dvd_mag = $unsigned(dividend[OP_W-1] ? -dividend : dividend);
        dvs_mag = $unsigned(divisor[OP_W-1] ? -divisor : divisor);
        partial = {rem_q, quo_q[OP_W-1]};
        fits    = partial >= {1'b0, dvs_q};
        // Only used when it fits, so the result is below dvs_q and needs OP_W bits
        diff    = partial[OP_W-1:0] - dvs_q;
        // Extra bit so MIN / -1 is representable
        quo_ext   = {1'b0, quo_q};
        quotient  = q_neg_q ? -quo_ext : quo_ext;
        remainder = r_neg_q ? $signed(-rem_q) : $signed(rem_q);
        done      = (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (start) begin
            cnt_q   <= CNT_W'(OP_W);
            quo_q   <= dvd_mag;
            rem_q   <= '0;
            dvs_q   <= dvs_mag;
            q_neg_q <= dividend[OP_W-1] ^ divisor[OP_W-1];
            r_neg_q <= dividend[OP_W-1];
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            quo_q <= {quo_q[OP_W-2:0], fits};
            rem_q <= fits ? diff : partial[OP_W-1:0];
        end
    end

endmodule
`endif

// File: rtl/instr_register_param.sv
// Instruction register: DEPTH entries of {opc, op_a, op_b, result, err}.
//
// Ports:
//   clk      : clock, all state on its rising edge
//   reset_n  : asynchronous active-low reset, clears every entry and the read port
//   bus      : instr_register_param_if.slave (write request, wr_ready,
//              read_pointer, instruction_word, rd_valid)
// Writes are accepted when load_en & wr_ready; reads have one cycle of latency
// and return the old contents when the same entry is written in that cycle.
//
// Configuration macro INSTR_REG_DIVMOD_EN: when defined, DIV/MOD with a non-zero
// divisor run on the iterative divider (wr_ready low until the entry is written).
// When undefined, every DIV/MOD writes result=0, err=1 in a single cycle.
module instr_register_param
    import instr_register_pkg::*;
#(
    parameter int unsigned OP_W   = OP_W_PKG,
    parameter int unsigned DEPTH  = DEPTH_PKG,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input logic                    clk,
    input logic                    reset_n,
    instr_register_param_if.slave  bus
);

    // Port types come from the package, so the parameters must agree with it
    if (OP_W != OP_W_PKG || ADDR_W != ADDR_W_PKG || DEPTH < 2 ||
        DEPTH != (32'd1 << ADDR_W)) begin : g_param_check
        $error("instr_register_param: parameters disagree with instr_register_pkg");
    end

    instruction_t     mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    instruction_t     rd_word_q;
    logic             rd_valid_q;
    logic             ready_q;

    logic             accept;
    result_t          a_ext, b_ext;
    instruction_t     fast_word;
    logic             wr_en;
    addr_t            wr_addr;
    instruction_t     wr_word;

    assign accept = bus.load_en & ready_q;

    assign bus.wr_ready         = ready_q;
    assign bus.instruction_word = rd_word_q;
    assign bus.rd_valid         = rd_valid_q;

    // Single-cycle operations; DIV/MOD here is the error/disabled path
    always_comb begin
        a_ext          = sext_op(bus.operand_a);
        b_ext          = sext_op(bus.operand_b);
        fast_word      = '0;
        fast_word.opc  = bus.opcode;
        fast_word.op_a = bus.operand_a;
        fast_word.op_b = bus.operand_b;
        case (bus.opcode)
            ZERO:    fast_word.result = '0;
            PASSA:   fast_word.result = a_ext;
            PASSB:   fast_word.result = b_ext;
            ADD:     fast_word.result = a_ext + b_ext;
            SUB:     fast_word.result = a_ext - b_ext;
            MULT:    fast_word.result = a_ext * b_ext;
            default: begin
                fast_word.result = '0;
                fast_word.err    = 1'b1;
            end
        endcase
    end

`ifdef INSTR_REG_DIVMOD_EN
    state_t              state_q, state_d;
    logic                is_div, div_start, div_done;
    logic signed [OP_W:0] div_quo;
    operand_t            div_rem;
    opcode_t             lat_opc_q;
    operand_t            lat_a_q, lat_b_q;
    addr_t               lat_addr_q;
    instruction_t        div_word;

    assign is_div    = (bus.opcode == DIV) || (bus.opcode == MOD);
    assign div_start = accept && is_div && (bus.operand_b != '0);

    instr_div_seq #(
        .OP_W (OP_W)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (bus.operand_a),
        .divisor   (bus.operand_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        div_word      = '0;
        div_word.opc  = lat_opc_q;
        div_word.op_a = lat_a_q;
        div_word.op_b = lat_b_q;
        div_word.result = (lat_opc_q == DIV) ? {{(OP_W-1){div_quo[OP_W]}}, div_quo}
                                             : sext_op(div_rem);
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_addr = bus.write_pointer;
        wr_word = fast_word;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (div_start) state_d = DIV_RUN;
                    else           wr_en   = 1'b1;
                end
            end
            DIV_RUN: begin
                if (div_done) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                wr_en   = 1'b1;
                wr_addr = lat_addr_q;
                wr_word = div_word;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            lat_opc_q  <= ZERO;
            lat_a_q    <= '0;
            lat_b_q    <= '0;
            lat_addr_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            if (div_start) begin
                lat_opc_q  <= bus.opcode;
                lat_a_q    <= bus.operand_a;
                lat_b_q    <= bus.operand_b;
                lat_addr_q <= bus.write_pointer;
            end
        end
    end
`else
    assign wr_en   = accept;
    assign wr_addr = bus.write_pointer;
    assign wr_word = fast_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_q <= 1'b0;
        else          ready_q <= 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            valid_q <= '0;
        end else if (wr_en) begin
            mem_q[wr_addr]   <= wr_word;
            valid_q[wr_addr] <= 1'b1;
        end
    end

    // Registered read samples the array before this edge's write lands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_word_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_word_q  <= mem_q[bus.read_pointer];
            rd_valid_q <= valid_q[bus.read_pointer];
        end
    end

endmodule

// File: tb/tb_instr_register_param.sv
// Directed self-checking bench for instr_register_param.
module tb_instr_register_param;
    import instr_register_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    instr_register_param_if bus_if ();

    instr_register_param dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        addr_t    wp;
        opcode_t  op;
        operand_t a;
        operand_t b;
        result_t  r;
        logic     err;
    } vec_t;

    task automatic idle_inputs();
        bus_if.load_en       = 1'b0;
        bus_if.write_pointer = '0;
        bus_if.operand_a     = '0;
        bus_if.operand_b     = '0;
        bus_if.opcode        = ZERO;
        bus_if.read_pointer  = '0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic write_op(input addr_t wp, input opcode_t op, input operand_t a,
                            input operand_t b);
        bus_if.write_pointer = wp;
        bus_if.opcode        = op;
        bus_if.operand_a     = a;
        bus_if.operand_b     = b;
        bus_if.load_en       = 1'b1;
        @(negedge clk);
        bus_if.load_en = 1'b0;
    endtask

    task automatic read_at(input addr_t rp, output instruction_t w, output logic v);
        bus_if.read_pointer = rp;
        @(negedge clk);
        w = bus_if.instruction_word;
        v = bus_if.rd_valid;
    endtask

    task automatic wait_ready(output int lows, output logic timed_out);
        lows      = 0;
        timed_out = 1'b0;
        while (bus_if.wr_ready !== 1'b1) begin
            if (lows >= 100) begin
                timed_out = 1'b1;
                break;
            end
            lows++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        instruction_t w;
        logic         v;
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (bus_if.wr_ready !== 1'b0) begin
            errors++; $display("FAIL reset_wr_ready: got %b want 0", bus_if.wr_ready);
        end
        checks++;
        if (bus_if.instruction_word !== '0) begin
            errors++; $display("FAIL reset_word: got %h want 0", bus_if.instruction_word);
        end
        checks++;
        if (bus_if.rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rd_valid: got %b want 0", bus_if.rd_valid);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_if.wr_ready !== 1'b1) begin
            errors++; $display("FAIL release_wr_ready: got %b want 1", bus_if.wr_ready);
        end
        for (int i = 0; i < 32; i++) begin
            read_at(addr_t'(i), w, v);
            checks++;
            if (w !== '0 || v !== 1'b0) begin
                errors++;
                $display("FAIL reset_entry_%0d: got word=%h valid=%b want 0/0", i, w, v);
            end
        end
    endtask

    task automatic test_add();
        instruction_t w;
        logic         v;
        write_op(addr_t'(3), ADD, -7, 5);
        read_at(addr_t'(3), w, v);
        checks++;
        if (w.result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++; $display("FAIL add_result: got %h want fffffffffffffffe", w.result);
        end
        checks++;
        if (w.opc !== ADD || w.err !== 1'b0 || v !== 1'b1) begin
            errors++;
            $display("FAIL add_fields: got opc=%0d err=%b valid=%b want 3/0/1", w.opc, w.err, v);
        end
        checks++;
        if (w.op_a !== -32'sd7 || w.op_b !== 32'sd5) begin
            errors++; $display("FAIL add_operands: got %h %h want fffffff9 00000005",
                               w.op_a, w.op_b);
        end
    endtask

    // Back-to-back writes (load_en held high across consecutive edges)
    task automatic test_mult();
        instruction_t w;
        logic         v;
        vec_t vecs[4];
        vecs[0] = '{addr_t'(0), MULT, 32'h7FFF_FFFF, 32'sd2, 64'h0000_0000_FFFF_FFFE, 1'b0};
        vecs[1] = '{addr_t'(1), MULT, -32'sd1, -32'sd1, 64'h0000_0000_0000_0001, 1'b0};
        vecs[2] = '{addr_t'(2), MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000,
                    1'b0};
        vecs[3] = '{addr_t'(4), MULT, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000,
                    1'b0};
        foreach (vecs[i]) write_op(vecs[i].wp, vecs[i].op, vecs[i].a, vecs[i].b);
        foreach (vecs[i]) begin
            read_at(vecs[i].wp, w, v);
            checks++;
            if (w.result !== vecs[i].r || w.err !== vecs[i].err || v !== 1'b1) begin
                errors++;
                $display("FAIL mult_%0d: got r=%h err=%b v=%b want r=%h err=%b v=1",
                         i, w.result, w.err, v, vecs[i].r, vecs[i].err);
            end
        end
    endtask

    task automatic test_misc_ops();
        instruction_t w;
        logic         v;
        vec_t vecs[6];
        vecs[0] = '{addr_t'(10), PASSA, -32'sd3, 32'sd99, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[1] = '{addr_t'(11), PASSB, 32'sd5, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[2] = '{addr_t'(12), SUB, 32'h8000_0000, 32'sd1, 64'hFFFF_FFFF_7FFF_FFFF, 1'b0};
        vecs[3] = '{addr_t'(13), ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h0000_0000_FFFF_FFFE,
                    1'b0};
        vecs[4] = '{addr_t'(14), ZERO, 32'sd123, 32'sd456, 64'h0, 1'b0};
        vecs[5] = '{addr_t'(15), SUB, 32'sd5, 32'sd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        foreach (vecs[i]) write_op(vecs[i].wp, vecs[i].op, vecs[i].a, vecs[i].b);
        foreach (vecs[i]) begin
            read_at(vecs[i].wp, w, v);
            checks++;
            if (w.result !== vecs[i].r || w.opc !== vecs[i].op || w.err !== vecs[i].err ||
                v !== 1'b1) begin
                errors++;
                $display("FAIL misc_%0d: got opc=%0d r=%h err=%b v=%b want opc=%0d r=%h err=%b v=1",
                         i, w.opc, w.result, w.err, v, vecs[i].op, vecs[i].r, vecs[i].err);
            end
        end
    endtask

    task automatic test_div_by_zero();
        instruction_t w;
        logic         v;
        write_op(addr_t'(9), DIV, 32'sd20, 32'sd0);
        checks++;
        if (bus_if.wr_ready !== 1'b1) begin
            errors++; $display("FAIL div0_wr_ready: got %b want 1", bus_if.wr_ready);
        end
        write_op(addr_t'(16), MOD, -32'sd20, 32'sd0);
        read_at(addr_t'(9), w, v);
        checks++;
        if (w.result !== 64'h0 || w.err !== 1'b1 || w.opc !== DIV || v !== 1'b1) begin
            errors++; $display("FAIL div0_entry: got r=%h err=%b opc=%0d v=%b want 0/1/6/1",
                               w.result, w.err, w.opc, v);
        end
        read_at(addr_t'(16), w, v);
        checks++;
        if (w.result !== 64'h0 || w.err !== 1'b1 || w.opc !== MOD || v !== 1'b1) begin
            errors++; $display("FAIL mod0_entry: got r=%h err=%b opc=%0d v=%b want 0/1/7/1",
                               w.result, w.err, w.opc, v);
        end
    endtask

`ifdef INSTR_REG_DIVMOD_EN
    task automatic test_div();
        instruction_t w;
        logic         v;
        int           lows;
        logic         to;
        vec_t vecs[5];
        write_op(addr_t'(31), DIV, -32'sd17, 32'sd5);
        // Count low wr_ready cycles and try to sneak writes into entry 30
        lows = 0;
        while (bus_if.wr_ready !== 1'b1 && lows < 100) begin
            lows++;
            if (lows == 6 || lows == 32) begin
                bus_if.write_pointer = addr_t'(30);
                bus_if.opcode        = ADD;
                bus_if.operand_a     = 32'sd1;
                bus_if.operand_b     = 32'sd1;
                bus_if.load_en       = 1'b1;
            end else begin
                bus_if.load_en = 1'b0;
            end
            @(negedge clk);
        end
        bus_if.load_en = 1'b0;
        checks++;
        if (lows != 33) begin
            errors++; $display("FAIL div_busy_cycles: got %0d want 33", lows);
        end
        read_at(addr_t'(31), w, v);
        checks++;
        if (w.result !== 64'hFFFF_FFFF_FFFF_FFFD || w.err !== 1'b0 || w.opc !== DIV ||
            v !== 1'b1) begin
            errors++; $display("FAIL div_entry: got r=%h err=%b opc=%0d v=%b want -3/0/6/1",
                               w.result, w.err, w.opc, v);
        end
        read_at(addr_t'(30), w, v);
        checks++;
        if (v !== 1'b0 || w !== '0) begin
            errors++; $display("FAIL div_ignored_load: got valid=%b word=%h want 0/0", v, w);
        end
        vecs[0] = '{addr_t'(29), MOD, -32'sd17, 32'sd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[1] = '{addr_t'(28), DIV, 32'sd17, -32'sd5, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[2] = '{addr_t'(27), MOD, 32'sd17, -32'sd5, 64'h0000_0000_0000_0002, 1'b0};
        vecs[3] = '{addr_t'(26), DIV, 32'h8000_0000, -32'sd1, 64'h0000_0000_8000_0000, 1'b0};
        vecs[4] = '{addr_t'(25), MOD, 32'h8000_0000, -32'sd1, 64'h0, 1'b0};
        foreach (vecs[i]) begin
            write_op(vecs[i].wp, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_ready(lows, to);
            checks++;
            if (to || lows != 33) begin
                errors++; $display("FAIL divseq_%0d_busy: got %0d timeout=%b want 33", i, lows, to);
            end
            read_at(vecs[i].wp, w, v);
            checks++;
            if (w.result !== vecs[i].r || w.err !== 1'b0 || v !== 1'b1) begin
                errors++; $display("FAIL divseq_%0d: got r=%h err=%b v=%b want r=%h err=0 v=1",
                                   i, w.result, w.err, v, vecs[i].r);
            end
        end
    endtask
`else
    task automatic test_div();
        instruction_t w;
        logic         v;
        write_op(addr_t'(17), DIV, 32'sd20, 32'sd4);
        checks++;
        if (bus_if.wr_ready !== 1'b1) begin
            errors++; $display("FAIL nodiv_wr_ready_div: got %b want 1", bus_if.wr_ready);
        end
        write_op(addr_t'(18), MOD, 32'sd20, 32'sd4);
        checks++;
        if (bus_if.wr_ready !== 1'b1) begin
            errors++; $display("FAIL nodiv_wr_ready_mod: got %b want 1", bus_if.wr_ready);
        end
        read_at(addr_t'(17), w, v);
        checks++;
        if (w.result !== 64'h0 || w.err !== 1'b1 || w.opc !== DIV || v !== 1'b1) begin
            errors++; $display("FAIL nodiv_div_entry: got r=%h err=%b opc=%0d v=%b want 0/1/6/1",
                               w.result, w.err, w.opc, v);
        end
        read_at(addr_t'(18), w, v);
        checks++;
        if (w.result !== 64'h0 || w.err !== 1'b1 || w.opc !== MOD || v !== 1'b1) begin
            errors++; $display("FAIL nodiv_mod_entry: got r=%h err=%b opc=%0d v=%b want 0/1/7/1",
                               w.result, w.err, w.opc, v);
        end
    endtask
`endif

    task automatic test_reset_abort();
        instruction_t w;
        logic         v;
        write_op(addr_t'(5), DIV, 32'sd20, 32'sd4);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_if.wr_ready !== 1'b0 || bus_if.rd_valid !== 1'b0) begin
            errors++; $display("FAIL abort_async: got ready=%b valid=%b want 0/0",
                               bus_if.wr_ready, bus_if.rd_valid);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_if.wr_ready !== 1'b1) begin
            errors++; $display("FAIL abort_wr_ready: got %b want 1", bus_if.wr_ready);
        end
        read_at(addr_t'(5), w, v);
        checks++;
        if (w !== '0 || v !== 1'b0) begin
            errors++; $display("FAIL abort_entry5: got word=%h valid=%b want 0/0", w, v);
        end
        read_at(addr_t'(3), w, v);
        checks++;
        if (w !== '0 || v !== 1'b0) begin
            errors++; $display("FAIL abort_entry3_cleared: got word=%h valid=%b want 0/0", w, v);
        end
    endtask

    task automatic test_read_before_write();
        write_op(addr_t'(7), ADD, 32'sd1, 32'sd2);
        bus_if.read_pointer  = addr_t'(7);
        bus_if.write_pointer = addr_t'(7);
        bus_if.opcode        = SUB;
        bus_if.operand_a     = 32'sd10;
        bus_if.operand_b     = 32'sd4;
        bus_if.load_en       = 1'b1;
        @(negedge clk);
        bus_if.load_en = 1'b0;
        checks++;
        if (bus_if.instruction_word.result !== 64'd3 || bus_if.instruction_word.opc !== ADD) begin
            errors++; $display("FAIL rbw_old: got r=%h opc=%0d want 3/ADD",
                               bus_if.instruction_word.result, bus_if.instruction_word.opc);
        end
        @(negedge clk);
        checks++;
        if (bus_if.instruction_word.result !== 64'd6 || bus_if.instruction_word.opc !== SUB ||
            bus_if.rd_valid !== 1'b1) begin
            errors++; $display("FAIL rbw_new: got r=%h opc=%0d v=%b want 6/SUB/1",
                               bus_if.instruction_word.result, bus_if.instruction_word.opc,
                               bus_if.rd_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_mult();
        test_misc_ops();
        test_div_by_zero();
        test_div();
        test_reset_abort();
        test_read_before_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
